// File: rtl/pc_redirect_ctrl.sv
// Next-PC sequencer: arbitrates trap/mret/branch/jump redirects, validates targets,
// holds redirects across stalls and drives the PC load and pipeline flush strobes.
module pc_redirect_ctrl #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] BOOT_ADDR    = 32'h0000_0000,
  parameter int              IT_DEPTH     = 4096,
  parameter logic [XLEN-1:0] TRAP_VEC     = 32'h0000_0010,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            trap_req_i,
  input  logic            mret_req_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic            br_req_i,
  input  logic [XLEN-1:0] br_addr_i,
  input  logic            jmp_req_i,
  input  logic [XLEN-1:0] jmp_addr_i,
  output logic            pc_en_o,
  output logic            pc_write_flag_o,
  output logic [XLEN-1:0] pc_write_addr_o,
  output logic            flush_if_id_o,
  output logic            flush_id_ex_o,
  output logic            fetch_fault_o,
  output logic [XLEN-1:0] fault_addr_o,
  output logic            busy_o
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [XLEN:0] ADDR_LO = {1'b0, BOOT_ADDR};
  localparam logic [XLEN:0] ADDR_HI = {1'b0, BOOT_ADDR} + (XLEN+1)'(IT_DEPTH);

  typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_FLUSH} state_t;
  // Trap never waits, so only the stallable sources need a stored priority.
  typedef enum logic [1:0] {P_NONE = 2'd0, P_JMP = 2'd1, P_BR = 2'd2, P_MRET = 2'd3} prio_t;

  state_t          state_q, state_d;
  prio_t           pend_prio_q, pend_prio_d;
  logic [XLEN-1:0] pend_addr_q, pend_addr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] fault_addr_q, fault_addr_d;

  prio_t           req_prio, sel_prio;
  logic [XLEN-1:0] req_addr, sel_addr;
  logic            issue;
  logic [XLEN-1:0] raw_addr;
  logic            addr_ok;

  // Fixed priority among the stallable sources: mret > br > jmp.
  always_comb begin
    req_prio = P_NONE;
    req_addr = '0;
    if (mret_req_i) begin
      req_prio = P_MRET;
      req_addr = mepc_i;
    end else if (br_req_i) begin
      req_prio = P_BR;
      req_addr = br_addr_i;
    end else if (jmp_req_i) begin
      req_prio = P_JMP;
      req_addr = jmp_addr_i;
    end
  end

  // While holding, a strictly higher-priority newcomer replaces the pending redirect.
  always_comb begin
    sel_prio = pend_prio_q;
    sel_addr = pend_addr_q;
    if (req_prio > pend_prio_q) begin
      sel_prio = req_prio;
      sel_addr = req_addr;
    end
  end

  // NOTE: every signal assigned in this block gets a default first, so no latches are inferred.
  always_comb begin
    state_d     = state_q;
    pend_prio_d = pend_prio_q;
    pend_addr_d = pend_addr_q;
    cnt_d       = cnt_q;
    issue       = 1'b0;
    raw_addr    = '0;
    if (!rst) begin
      unique case (state_q)
        ST_RUN: begin
          if (trap_req_i) begin
            issue    = 1'b1;
            raw_addr = TRAP_VEC;
          end else if (req_prio != P_NONE) begin
            if (!stall_i) begin
              issue    = 1'b1;
              raw_addr = req_addr;
            end else begin
              pend_prio_d = req_prio;
              pend_addr_d = req_addr;
              state_d     = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (trap_req_i) begin
            issue    = 1'b1;
            raw_addr = TRAP_VEC;
          end else if (!stall_i) begin
            issue    = 1'b1;
            raw_addr = sel_addr;
          end else begin
            pend_prio_d = sel_prio;
            pend_addr_d = sel_addr;
          end
        end
        ST_FLUSH: begin
          if (trap_req_i) begin
            issue    = 1'b1;
            raw_addr = TRAP_VEC;
          end else if (cnt_q <= CW'(1)) begin
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
    if (issue) begin
      state_d     = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
      cnt_d       = CW'(FLUSH_CYCLES - 1);
      pend_prio_d = P_NONE;
      pend_addr_d = '0;
    end
  end

  // XLEN+1-bit range compare so BOOT_ADDR+IT_DEPTH cannot wrap.
  assign addr_ok = (raw_addr[1:0] == 2'b00) &&
                   ({1'b0, raw_addr} >= ADDR_LO) && ({1'b0, raw_addr} < ADDR_HI);

  always_comb begin
    fault_d      = issue && !addr_ok;
    fault_addr_d = fault_addr_q;
    if (issue && !addr_ok) fault_addr_d = raw_addr;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      pend_prio_q  <= P_NONE;
      pend_addr_q  <= '0;
      cnt_q        <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pend_prio_q  <= pend_prio_d;
      pend_addr_q  <= pend_addr_d;
      cnt_q        <= cnt_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign pc_write_flag_o = issue;
  assign pc_write_addr_o = issue ? (addr_ok ? raw_addr : TRAP_VEC) : '0;
  assign pc_en_o         = issue || !stall_i;
  assign flush_if_id_o   = issue || (!rst && state_q == ST_FLUSH);
  assign flush_id_ex_o   = issue;
  assign fetch_fault_o   = fault_q;
  assign fault_addr_o    = fault_addr_q;
  assign busy_o          = (state_q != ST_RUN);

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: hand-computed expectations checked with
// immediate assertions at mid-cycle (after the negedge input update).
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, trap_req_i, mret_req_i, br_req_i, jmp_req_i;
  logic [31:0] mepc_i, br_addr_i, jmp_addr_i;
  logic        pc_en_o, pc_write_flag_o, flush_if_id_o, flush_id_ex_o, fetch_fault_o, busy_o;
  logic [31:0] pc_write_addr_o, fault_addr_o;

  int vecs = 0;
  int errs = 0;

  pc_redirect_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .trap_req_i      (trap_req_i),
    .mret_req_i      (mret_req_i),
    .mepc_i          (mepc_i),
    .br_req_i        (br_req_i),
    .br_addr_i       (br_addr_i),
    .jmp_req_i       (jmp_req_i),
    .jmp_addr_i      (jmp_addr_i),
    .pc_en_o         (pc_en_o),
    .pc_write_flag_o (pc_write_flag_o),
    .pc_write_addr_o (pc_write_addr_o),
    .flush_if_id_o   (flush_if_id_o),
    .flush_id_ex_o   (flush_id_ex_o),
    .fetch_fault_o   (fetch_fault_o),
    .fault_addr_o    (fault_addr_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic en, input logic flag,
                            input logic [31:0] addr, input logic fif, input logic fie,
                            input logic busy);
    chk({tag, ".pc_en"}, {31'b0, pc_en_o}, {31'b0, en});
    chk({tag, ".flag"},  {31'b0, pc_write_flag_o}, {31'b0, flag});
    chk({tag, ".addr"},  pc_write_addr_o, addr);
    chk({tag, ".fif"},   {31'b0, flush_if_id_o}, {31'b0, fif});
    chk({tag, ".fie"},   {31'b0, flush_id_ex_o}, {31'b0, fie});
    chk({tag, ".busy"},  {31'b0, busy_o}, {31'b0, busy});
  endtask

  task automatic expect_fault(input string tag, input logic f, input logic [31:0] fa);
    chk({tag, ".fault"},      {31'b0, fetch_fault_o}, {31'b0, f});
    chk({tag, ".fault_addr"}, fault_addr_o, fa);
  endtask

  // Apply one cycle of inputs just after the negedge, settle, then check.
  task automatic drive(input logic st, input logic tr, input logic mr, input logic [31:0] me,
                       input logic b, input logic [31:0] ba, input logic j, input logic [31:0] ja);
    @(negedge clk);
    stall_i = st; trap_req_i = tr; mret_req_i = mr; mepc_i = me;
    br_req_i = b; br_addr_i = ba; jmp_req_i = j; jmp_addr_i = ja;
    #1;
  endtask

  task automatic idle(input logic st);
    drive(st, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    stall_i = 1'b0; trap_req_i = 1'b0; mret_req_i = 1'b0; br_req_i = 1'b0; jmp_req_i = 1'b0;
    mepc_i = '0; br_addr_i = '0; jmp_addr_i = '0;
    #3;
    expect_out("reset", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_fault("reset", 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 1: idle after reset release
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      expect_out("idle", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    end

    // 2: branch to 0x40, no stall
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0);
    expect_out("br40.issue", 1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    expect_out("br40.flush", 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    idle(1'b0);
    expect_out("br40.run", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // 3: stalled jmp 0x20, then br 0x80 replaces it, then lower-priority jmp ignored
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h20);
    expect_out("hold.c1", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 32'h0);
    expect_out("hold.c2", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h24);
    expect_out("hold.c3", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    expect_out("hold.c4", 1'b1, 1'b1, 32'h80, 1'b1, 1'b1, 1'b1);
    idle(1'b0);
    expect_out("hold.flush", 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    idle(1'b0);
    expect_out("hold.run", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // 4: invalid targets replaced by the trap vector
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h42, 1'b0, 32'h0);
    expect_out("mis.issue", 1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0);
    expect_fault("mis.issue", 1'b0, 32'h0);
    idle(1'b0);
    expect_fault("mis.next", 1'b1, 32'h42);
    idle(1'b0);
    expect_fault("mis.after", 1'b0, 32'h42);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h2000, 1'b0, 32'h0);
    expect_out("oor.issue", 1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    expect_fault("oor.next", 1'b1, 32'h2000);
    idle(1'b0);
    // Last in-range word is valid; first out-of-range is not.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFC, 1'b0, 32'h0);
    expect_out("edge.ffc", 1'b1, 1'b1, 32'hFFC, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    expect_fault("edge.ffc", 1'b0, 32'h2000);
    idle(1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1000);
    expect_out("edge.1000", 1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    expect_fault("edge.1000", 1'b1, 32'h1000);
    idle(1'b0);

    // Priority without stall: mret over br over jmp
    drive(1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h20);
    expect_out("prio.mret", 1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0);
    idle(1'b0); idle(1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h84, 1'b1, 32'h20);
    expect_out("prio.br", 1'b1, 1'b1, 32'h84, 1'b1, 1'b1, 1'b0);
    idle(1'b0); idle(1'b0);

    // 5: trap beats mret/br even under stall; br in FLUSH ignored; trap in FLUSH re-issued
    drive(1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    expect_out("trap.issue", 1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 32'h0);
    expect_out("trap.brflush", 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    idle(1'b0);
    expect_out("trap.run", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_out("trap2.issue", 1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_out("trap2.reissue", 1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    expect_out("trap2.flush", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    idle(1'b0);
    expect_out("trap2.run", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // 6: async reset mid-HOLD drops the pending redirect
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 32'h0);
    idle(1'b1);
    expect_out("rsthold.pre", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    expect_out("rsthold.async", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_fault("rsthold.async", 1'b0, 32'h0);
    stall_i = 1'b0;
    #1;
    chk("rsthold.pc_en", {31'b0, pc_en_o}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      idle(1'b0);
      expect_out("rsthold.after", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
